// File: rtl/mem_arbiter.sv
// mem_arbiter
// ---------------------------------------------------------------------------
// Byte-serial memory controller. The instruction cache (word fetches) and the
// load/store buffer (1/2/4-byte loads and stores) share one 8-bit RAM/IO port.
// Each access is split into per-byte address/data beats. Read bytes are
// reassembled little-endian. IO writes are held back while the IO sink is
// full. A rollback abandons speculative reads so the front end can refetch at
// once.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   rdy               global enable, low freezes every register
//   rollback          misprediction flush
//   ic_req/ic_addr    icache fetch request (level) and word address
//   ic_done/ic_data   one-cycle acknowledge and fetched word
//   ls_req/ls_wr      LSB request (level); 1 = store, 0 = load
//   ls_len            00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes
//   ls_addr/ls_wdata  access address and store data (low byte first)
//   ls_done/ls_rdata  one-cycle acknowledge and zero-extended load data
//   mem_din           byte returned for the address driven last cycle
//   mem_dout/mem_a    write byte and byte address
//   mem_wr            1 = write beat
//   io_buffer_full    IO sink cannot take a write this cycle
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_LS = 1'b1
  } src_t;

  state_t      state_q, state_d;
  src_t        src_q, src_d;
  src_t        lastGrant_q, lastGrant_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  ai_q, ai_d;
  logic [2:0]  ci_q, ci_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] icData_q, icData_d;
  logic [31:0] lsRdata_q, lsRdata_d;
  logic        icDone_q, icDone_d;
  logic        lsDone_q, lsDone_d;
  logic [31:0] memA_q, memA_d;
  logic [7:0]  memDout_q, memDout_d;
  logic        memWr_q, memWr_d;

  logic        grantIc;
  logic        grantLs;
  logic [31:0] beatAddr;
  logic [31:0] assembled;

  function automatic logic isIo(input logic [1:0] hi);
    return hi == IO_ADDR_HI;
  endfunction

  // The reserved length code 10 is served as a full word.
  function automatic logic [2:0] lenToBytes(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // State and output registers. Every output is a flop; when rdy is low the
  // whole block holds, which also stretches a pending done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= SRC_IC;
      lastGrant_q <= SRC_LS;
      n_q         <= 3'd0;
      ai_q        <= 3'd0;
      ci_q        <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      icData_q    <= 32'd0;
      lsRdata_q   <= 32'd0;
      icDone_q    <= 1'b0;
      lsDone_q    <= 1'b0;
      memA_q      <= 32'd0;
      memDout_q   <= 8'd0;
      memWr_q     <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      src_q       <= src_d;
      lastGrant_q <= lastGrant_d;
      n_q         <= n_d;
      ai_q        <= ai_d;
      ci_q        <= ci_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      icData_q    <= icData_d;
      lsRdata_q   <= lsRdata_d;
      icDone_q    <= icDone_d;
      lsDone_q    <= lsDone_d;
      memA_q      <= memA_d;
      memDout_q   <= memDout_d;
      memWr_q     <= memWr_d;
    end
  end

  // Next-state logic. The bus registers describe the beat for the *next*
  // cycle, so ai counts beats already placed on the bus: a grant drives beat 0
  // straight away and leaves ai at 1. In RD the byte answering the beat now on
  // the bus is captured at every edge, so ci trails ai by exactly one.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    lastGrant_d = lastGrant_q;
    n_d         = n_q;
    ai_d        = ai_q;
    ci_d        = ci_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    icData_d    = icData_q;
    lsRdata_d   = lsRdata_q;
    icDone_d    = 1'b0;
    lsDone_d    = 1'b0;
    memA_d      = 32'd0;
    memDout_d   = 8'd0;
    memWr_d     = 1'b0;
    grantIc     = 1'b0;
    grantLs     = 1'b0;
    beatAddr    = base_q + {29'd0, ai_q};
    assembled   = buf_q;
    assembled[{ci_q[1:0], 3'b000} +: 8] = mem_din;

    case (state_q)
      IDLE: begin
        // A rollback cycle grants nothing. On a conflict the requester that
        // was not served last wins.
        if (!rollback) begin
          if (ic_req && (!ls_req || lastGrant_q == SRC_LS)) begin
            grantIc = 1'b1;
          end else if (ls_req) begin
            grantLs = 1'b1;
          end
        end

        if (grantIc) begin
          src_d       = SRC_IC;
          lastGrant_d = SRC_IC;
          n_d         = 3'd4;
          base_d      = ic_addr;
          buf_d       = 32'd0;
          ci_d        = 3'd0;
          ai_d        = 3'd1;
          memA_d      = ic_addr;
          state_d     = RD;
        end else if (grantLs) begin
          src_d       = SRC_LS;
          lastGrant_d = SRC_LS;
          n_d         = lenToBytes(ls_len);
          base_d      = ls_addr;
          wdata_d     = ls_wdata;
          buf_d       = 32'd0;
          ci_d        = 3'd0;
          if (ls_wr) begin
            state_d = WR;
            // The first store beat is already subject to IO back-pressure.
            if (isIo(ls_addr[17:16]) && io_buffer_full) begin
              ai_d = 3'd0;
            end else begin
              ai_d      = 3'd1;
              memA_d    = ls_addr;
              memDout_d = ls_wdata[7:0];
              memWr_d   = 1'b1;
            end
          end else begin
            state_d = RD;
            ai_d    = 3'd1;
            memA_d  = ls_addr;
          end
        end
      end

      RD: begin
        // Fetches and ordinary loads are speculative and may be dropped; IO
        // loads have side effects and always run to completion.
        if (rollback && (src_q == SRC_IC || !isIo(base_q[17:16]))) begin
          state_d = IDLE;
        end else if (ai_q > ci_q) begin
          buf_d = assembled;
          ci_d  = ci_q + 3'd1;
          if (ci_q + 3'd1 == n_q) begin
            state_d = DONE;
            if (src_q == SRC_IC) begin
              icData_d = assembled;
              icDone_d = 1'b1;
            end else begin
              lsRdata_d = assembled;
              lsDone_d  = 1'b1;
            end
          end else if (ai_q < n_q) begin
            memA_d = beatAddr;
            ai_d   = ai_q + 3'd1;
          end
        end
      end

      WR: begin
        // Stores are never aborted. A beat towards a full IO sink is simply
        // not issued and ai waits for the next cycle.
        if (ai_q == n_q) begin
          state_d  = DONE;
          lsDone_d = 1'b1;
        end else if (!(isIo(beatAddr[17:16]) && io_buffer_full)) begin
          memA_d    = beatAddr;
          memDout_d = wdata_q[{ai_q[1:0], 3'b000} +: 8];
          memWr_d   = 1'b1;
          ai_d      = ai_q + 3'd1;
        end
      end

      DONE: begin
        // The acknowledge is already on the outputs; requests are ignored
        // here so the requester has one cycle to drop its level.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ic_done  = icDone_q;
  assign ic_data  = icData_q;
  assign ls_done  = lsDone_q;
  assign ls_rdata = lsRdata_q;
  assign mem_a    = memA_q;
  assign mem_dout = memDout_q;
  // A frozen write beat stays on the bus but must not be committed twice, so
  // the strobe is masked for as long as the block is stalled.
  assign mem_wr   = memWr_q & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed requests push expected
// responses into queues, a negedge monitor pops and compares them whenever
// the design acknowledges or issues a write beat.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        icReq;
  logic [31:0] icAddr;
  logic        icDone;
  logic [31:0] icData;
  logic        lsReq;
  logic        lsWr;
  logic [1:0]  lsLen;
  logic [31:0] lsAddr;
  logic [31:0] lsWdata;
  logic        lsDone;
  logic [31:0] lsRdata;
  logic [7:0]  memDin;
  logic [7:0]  memDout;
  logic [31:0] memA;
  logic        memWr;
  logic        ioFull;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } beat_t;

  resp_t icExp[$];
  resp_t lsExp[$];
  beat_t wrExp[$];
  resp_t icE;
  resp_t lsE;
  beat_t wrE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] ram [0:262143];

  always #5 clk = ~clk;

  mem_arbiter #(.IO_ADDR_HI(2'b11)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .ic_req         (icReq),
    .ic_addr        (icAddr),
    .ic_done        (icDone),
    .ic_data        (icData),
    .ls_req         (lsReq),
    .ls_wr          (lsWr),
    .ls_len         (lsLen),
    .ls_addr        (lsAddr),
    .ls_wdata       (lsWdata),
    .ls_done        (lsDone),
    .ls_rdata       (lsRdata),
    .mem_din        (memDin),
    .mem_dout       (memDout),
    .mem_a          (memA),
    .mem_wr         (memWr),
    .io_buffer_full (ioFull)
  );

  // RAM model: combinational read of the address on the bus, write on edge.
  assign memDin = ram[memA[17:0]];

  always @(posedge clk) begin
    if (memWr) ram[memA[17:0]] <= memDout;
  end

  initial begin
    ram[18'h00100] <= 8'h13; ram[18'h00101] <= 8'h05;
    ram[18'h00102] <= 8'h00; ram[18'h00103] <= 8'h00;
    ram[18'h00300] <= 8'hEF; ram[18'h00301] <= 8'hBE;
    ram[18'h00302] <= 8'hAD; ram[18'h00303] <= 8'hDE;
    ram[18'h00400] <= 8'h93; ram[18'h00401] <= 8'h00;
    ram[18'h00402] <= 8'h10; ram[18'h00403] <= 8'h00;
    ram[18'h00500] <= 8'h44; ram[18'h00501] <= 8'h33;
    ram[18'h00502] <= 8'h22; ram[18'h00503] <= 8'h11;
    ram[18'h00504] <= 8'h88; ram[18'h00505] <= 8'h77;
    ram[18'h00506] <= 8'h66; ram[18'h00507] <= 8'h55;
    ram[18'h00600] <= 8'hCC; ram[18'h00601] <= 8'hBB;
    ram[18'h00602] <= 8'hAA; ram[18'h00603] <= 8'h99;
    ram[18'h30001] <= 8'h9C;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual %h required %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lenBytes(input logic [1:0] len);
    if (len == 2'b00) return 1;
    if (len == 2'b01) return 2;
    return 4;
  endfunction

  // Raise one request at the current cycle, queue its expected response
  // (lat = cycles from raising the request to seeing done, -1 = unchecked),
  // then hold the request until done appears.
  task automatic applyStimulus(input bit isLs, input bit wr, input logic [1:0] len,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input int lat);
    resp_t e;
    beat_t b;
    int t;
    e.data = expData;
    e.cyc  = (lat < 0) ? -1 : cyc + lat;
    e.chk  = !(isLs && wr);
    if (isLs) begin
      lsWr    = wr;
      lsLen   = len;
      lsAddr  = addr;
      lsWdata = wdata;
      lsExp.push_back(e);
      if (wr) begin
        for (int i = 0; i < lenBytes(len); i++) begin
          b.addr = addr + i;
          b.data = wdata[8*i +: 8];
          wrExp.push_back(b);
        end
      end
      lsReq = 1'b1;
    end else begin
      icAddr = addr;
      icExp.push_back(e);
      icReq = 1'b1;
    end
    t = 0;
    while (!(isLs ? lsDone : icDone) && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) checkOutput("reqTimeout", 32'd0, 32'd1);
    if (isLs) lsReq = 1'b0;
    else icReq = 1'b0;
  endtask

  // Monitor: compares acknowledges and write beats against the queues.
  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (icDone) begin
        if (icExp.size() == 0) begin
          checkOutput("icSpuriousDone", 32'd1, 32'd0);
        end else begin
          icE = icExp.pop_front();
          checkOutput("icData", icData, icE.data);
          if (icE.cyc >= 0) checkOutput("icLatency", cyc, icE.cyc);
        end
      end
      if (lsDone) begin
        if (lsExp.size() == 0) begin
          checkOutput("lsSpuriousDone", 32'd1, 32'd0);
        end else begin
          lsE = lsExp.pop_front();
          if (lsE.chk) checkOutput("lsRdata", lsRdata, lsE.data);
          if (lsE.cyc >= 0) checkOutput("lsLatency", cyc, lsE.cyc);
        end
      end
      if (memWr) begin
        checkOutput("ioThrottle", {31'd0, ioFull && memA[17:16] == 2'b11}, 32'd0);
        if (wrExp.size() == 0) begin
          checkOutput("spuriousWrite", memA, 32'hFFFF_FFFF);
        end else begin
          wrE = wrExp.pop_front();
          checkOutput("wrAddr", memA, wrE.addr);
          checkOutput("wrData", {24'd0, memDout}, {24'd0, wrE.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual running required finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    icReq = 1'b0; icAddr = '0;
    lsReq = 1'b0; lsWr = 1'b0; lsLen = '0; lsAddr = '0; lsWdata = '0;
    ioFull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstIcDone", {31'd0, icDone}, 32'd0);
    checkOutput("rstLsDone", {31'd0, lsDone}, 32'd0);
    checkOutput("rstIcData", icData, 32'd0);
    checkOutput("rstLsRdata", lsRdata, 32'd0);
    checkOutput("rstMemA", memA, 32'd0);
    checkOutput("rstMemDout", {24'd0, memDout}, 32'd0);
    checkOutput("rstMemWr", {31'd0, memWr}, 32'd0);

    // Word fetch with the address beats watched cycle by cycle.
    step();
    fork
      applyStimulus(1'b0, 1'b0, 2'b11, 32'h100, 32'h0, 32'h0000_0513, 5);
      begin
        for (int i = 0; i < 4; i++) begin
          step();
          checkOutput("rdBeatAddr", memA, 32'h100 + i);
        end
        step();
        checkOutput("idleBusAfterRead", memA, 32'd0);
      end
    join

    // Halfword store, read back as halfword and as byte.
    step();
    applyStimulus(1'b1, 1'b1, 2'b01, 32'h200, 32'hA1B2_C3D4, 32'h0, 3);
    step();
    applyStimulus(1'b1, 1'b0, 2'b01, 32'h200, 32'h0, 32'h0000_C3D4, 3);
    step();
    applyStimulus(1'b1, 1'b0, 2'b00, 32'h201, 32'h0, 32'h0000_00C3, 2);

    // Conflict from reset: IC first, then LS beats a re-raised IC.
    step();
    fork
      begin
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h500, 32'h0, 32'h1122_3344, 5);
        step();
        applyStimulus(1'b0, 1'b0, 2'b11, 32'h504, 32'h0, 32'h5566_7788, 11);
      end
      applyStimulus(1'b1, 1'b0, 2'b11, 32'h600, 32'h0, 32'h99AA_BBCC, 11);
    join

    // IO byte store held off by a full sink for three cycles.
    step();
    fork
      applyStimulus(1'b1, 1'b1, 2'b00, 32'h30000, 32'h0000_005A, 32'h0, 5);
      begin
        ioFull = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ioFull = 1'b0;
      end
    join

    // Rollback during the second beat of a fetch, then an immediate refetch.
    step();
    icAddr = 32'h100;
    icReq  = 1'b1;
    step();
    step();
    checkOutput("rbBeat2Addr", memA, 32'h101);
    rollback = 1'b1;
    icReq    = 1'b0;
    step();
    rollback = 1'b0;
    checkOutput("rbIdleAddr", memA, 32'd0);
    checkOutput("rbNoWr", {31'd0, memWr}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b11, 32'h400, 32'h0, 32'h0010_0093, 5);

    // Rollback cannot stop a store.
    step();
    fork
      applyStimulus(1'b1, 1'b1, 2'b11, 32'h210, 32'h1122_3344, 32'h0, 5);
      begin
        step();
        step();
        rollback = 1'b1;
        step();
        rollback = 1'b0;
      end
    join

    // Rollback cannot stop an IO load.
    step();
    fork
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h30001, 32'h0, 32'h0000_009C, 2);
      begin
        step();
        rollback = 1'b1;
        step();
        rollback = 1'b0;
      end
    join

    // Rollback drops an ordinary load without an acknowledge.
    step();
    lsWr   = 1'b0;
    lsLen  = 2'b11;
    lsAddr = 32'h600;
    lsReq  = 1'b1;
    step();
    rollback = 1'b1;
    lsReq    = 1'b0;
    step();
    rollback = 1'b0;
    checkOutput("rbLsIdleAddr", memA, 32'd0);

    // Two stalled cycles in the middle of a fetch.
    step();
    fork
      applyStimulus(1'b0, 1'b0, 2'b11, 32'h300, 32'h0, 32'hDEAD_BEEF, 7);
      begin
        step();
        step();
        rdy = 1'b0;
        step();
        checkOutput("frzAddr1", memA, 32'h301);
        step();
        checkOutput("frzAddr2", memA, 32'h301);
        rdy = 1'b1;
      end
    join

    repeat (10) step();
    checkOutput("icQueueEmpty", icExp.size(), 32'd0);
    checkOutput("lsQueueEmpty", lsExp.size(), 32'd0);
    checkOutput("wrQueueEmpty", wrExp.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
